// File: rtl/mario_obj_dma_if.sv
// Bus bundle between the sprite DMA controller and its surroundings:
// CPU trigger, Z80 bus handshake, work-RAM read port and object-RAM write port.
interface mario_obj_dma_if;
  logic       I_CEN;
  logic       I_TRIG;
  logic       I_BANK;
  logic       O_BUSRQn;
  logic       I_BUSAKn;
  logic [9:0] O_SRC_A;
  logic       O_SRC_RDn;
  logic [7:0] I_SRC_D;
  logic [9:0] O_OBJ_DMA_A;
  logic [7:0] O_OBJ_DMA_D;
  logic       O_OBJ_DMA_CE;
  logic       O_BUSY;
  logic       O_DONE;

  modport master (
    input  I_CEN, I_TRIG, I_BANK, I_BUSAKn, I_SRC_D,
    output O_BUSRQn, O_SRC_A, O_SRC_RDn, O_OBJ_DMA_A, O_OBJ_DMA_D,
    output O_OBJ_DMA_CE, O_BUSY, O_DONE
  );

  modport slave (
    output I_CEN, I_TRIG, I_BANK, I_BUSAKn, I_SRC_D,
    input  O_BUSRQn, O_SRC_A, O_SRC_RDn, O_OBJ_DMA_A, O_OBJ_DMA_D,
    input  O_OBJ_DMA_CE, O_BUSY, O_DONE
  );
endinterface

// File: rtl/mario_obj_dma.sv
// Sprite DMA: on a CPU trigger, grabs the Z80 bus and copies XFER_LEN bytes of
// work RAM (starting at SRC_BASE) into one bank of the 1KB object RAM.
module mario_obj_dma #(
  parameter logic [9:0] SRC_BASE = 10'h100,
  parameter int         XFER_LEN = 384
) (
  input  logic             I_CLK_48M,
  input  logic             I_RESET,
  mario_obj_dma_if.master  bus
);

  generate
    if (XFER_LEN < 1 || XFER_LEN > 512) begin : g_bad_len
      $error("mario_obj_dma: XFER_LEN must be within 1..512");
    end
  endgenerate

  localparam logic [9:0] LEN = 10'(XFER_LEN);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    READ,
    LATCH,
    WRITE,
    RELEASE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       trig_q;
  logic       pending;
  logic       bank;
  logic [9:0] index;
  logic [9:0] index_inc;
  logic [9:0] obj_a;
  logic [7:0] obj_d;
  logic       trig_rise;

  assign index_inc = index + 10'd1;
  assign trig_rise = bus.I_TRIG & ~trig_q;

  // trig_q follows the input even in reset so a trigger held across reset release is not seen as a new edge
  always_ff @(posedge I_CLK_48M) begin
    if (I_RESET) begin
      state   <= IDLE;
      trig_q  <= bus.I_TRIG;
      pending <= 1'b0;
      bank    <= 1'b0;
      index   <= 10'd0;
      obj_a   <= 10'd0;
      obj_d   <= 8'd0;
    end else begin
      state  <= state_next;
      trig_q <= bus.I_TRIG;
      if (state == IDLE && pending) begin
        pending <= 1'b0;
        bank    <= bus.I_BANK;
        index   <= 10'd0;
      end else if (state == IDLE && trig_rise) begin
        pending <= 1'b1;
      end
      // address and data are loaded one step early so they are stable while the write strobe is high
      if (bus.I_CEN && state == LATCH) begin
        obj_d <= bus.I_SRC_D;
        obj_a <= {bank, index[8:0]};
      end
      if (bus.I_CEN && state == WRITE) begin
        index <= index_inc;
      end
    end
  end

  always_comb begin
    state_next       = state;
    bus.O_BUSRQn     = 1'b1;
    bus.O_BUSY       = 1'b0;
    bus.O_SRC_RDn    = 1'b1;
    bus.O_OBJ_DMA_CE = 1'b0;
    bus.O_DONE       = 1'b0;
    case (state)
      IDLE: begin
        if (pending) state_next = REQ;
      end
      REQ: begin
        bus.O_BUSRQn = 1'b0;
        bus.O_BUSY   = 1'b1;
        if (bus.I_CEN) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        bus.O_BUSRQn = 1'b0;
        bus.O_BUSY   = 1'b1;
        if (bus.I_CEN && !bus.I_BUSAKn) state_next = READ;
      end
      READ: begin
        bus.O_BUSRQn  = 1'b0;
        bus.O_BUSY    = 1'b1;
        bus.O_SRC_RDn = 1'b0;
        if (bus.I_CEN) state_next = LATCH;
      end
      LATCH: begin
        bus.O_BUSRQn = 1'b0;
        bus.O_BUSY   = 1'b1;
        if (bus.I_CEN) state_next = WRITE;
      end
      WRITE: begin
        bus.O_BUSRQn     = 1'b0;
        bus.O_BUSY       = 1'b1;
        bus.O_OBJ_DMA_CE = bus.I_CEN;
        if (bus.I_CEN) state_next = (index_inc == LEN) ? RELEASE : READ;
      end
      RELEASE: begin
        bus.O_DONE = bus.I_CEN;
        if (bus.I_CEN) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // source address wraps naturally in the 10-bit sum
  assign bus.O_SRC_A     = SRC_BASE + index;
  assign bus.O_OBJ_DMA_A = obj_a;
  assign bus.O_OBJ_DMA_D = obj_d;

endmodule

// File: tb/tb_mario_obj_dma.sv
// Self-checking bench for mario_obj_dma: random work-RAM contents, a behavioural
// work/object RAM model, and directed trigger/ack/reset scenarios on two parameterisations.
module tb_mario_obj_dma;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic trig = 1'b0;
  logic bank_in = 1'b0;
  logic busak_n = 1'b1;
  logic sel = 1'b0;
  logic [7:0] src_d0 = 8'd0;
  logic [7:0] src_d1 = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] wram [1024];
  logic [7:0] obj_m [1024];
  int         obj_seq [1024];
  logic [9:0] rd_q [$];
  int ce_tot = 0;
  int done_tot = 0;
  int step_tot = 0;

  mario_obj_dma_if bus0 ();
  mario_obj_dma_if bus1 ();

  assign bus0.I_CEN    = cen;
  assign bus0.I_TRIG   = trig & ~sel;
  assign bus0.I_BANK   = bank_in;
  assign bus0.I_BUSAKn = busak_n;
  assign bus0.I_SRC_D  = src_d0;
  assign bus1.I_CEN    = cen;
  assign bus1.I_TRIG   = trig & sel;
  assign bus1.I_BANK   = bank_in;
  assign bus1.I_BUSAKn = busak_n;
  assign bus1.I_SRC_D  = src_d1;

  mario_obj_dma dut0 (.I_CLK_48M(clk), .I_RESET(rst), .bus(bus0));
  mario_obj_dma #(.SRC_BASE(10'h3F0), .XFER_LEN(32)) dut1 (.I_CLK_48M(clk), .I_RESET(rst), .bus(bus1));

  logic       busrq_v, rd_v, ce_v, busy_v, done_v;
  logic [9:0] src_a_v, obj_a_v;
  logic [7:0] obj_d_v;
  assign busrq_v = sel ? bus1.O_BUSRQn     : bus0.O_BUSRQn;
  assign rd_v    = sel ? bus1.O_SRC_RDn    : bus0.O_SRC_RDn;
  assign ce_v    = sel ? bus1.O_OBJ_DMA_CE : bus0.O_OBJ_DMA_CE;
  assign busy_v  = sel ? bus1.O_BUSY       : bus0.O_BUSY;
  assign done_v  = sel ? bus1.O_DONE       : bus0.O_DONE;
  assign src_a_v = sel ? bus1.O_SRC_A      : bus0.O_SRC_A;
  assign obj_a_v = sel ? bus1.O_OBJ_DMA_A  : bus0.O_OBJ_DMA_A;
  assign obj_d_v = sel ? bus1.O_OBJ_DMA_D  : bus0.O_OBJ_DMA_D;

  always #5 clk = ~clk;

  // CPU-rate step enable: one clock in three
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      cen = (ph == 0);
      ph = (ph + 1) % 3;
    end
  end

  // work RAM with synchronous read, data valid on the step after the address
  always @(posedge clk) begin
    if (cen && !bus0.O_SRC_RDn) src_d0 <= wram[bus0.O_SRC_A];
    if (cen && !bus1.O_SRC_RDn) src_d1 <= wram[bus1.O_SRC_A];
  end

  // object RAM model and activity counters for the selected DUT
  always @(posedge clk) begin
    if (ce_v) begin
      obj_m[obj_a_v]   <= obj_d_v;
      obj_seq[obj_a_v] <= ce_tot + 1;
      ce_tot           <= ce_tot + 1;
    end
    if (cen && !rd_v) rd_q.push_back(src_a_v);
    if (done_v) done_tot <= done_tot + 1;
    if (cen && (busy_v || done_v)) step_tot <= step_tot + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_steps(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!cen) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    repeat (2) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic apply_stimulus(input logic s, input int ack_delay, input logic bank,
                                input logic toggle, input logic retrig, input string tag);
    logic [9:0] base;
    int len, dst, ce0, done0, step0, rd0, bad, waited;
    logic [9:0] sa;
    sel = s;
    base = s ? 10'h3F0 : 10'h100;
    len  = s ? 32 : 384;
    dst  = bank ? 512 : 0;
    for (int i = 0; i < 1024; i++) wram[i] = 8'($urandom);
    @(negedge clk);
    ce0 = ce_tot; done0 = done_tot; step0 = step_tot; rd0 = rd_q.size();
    bank_in = bank;
    if (ack_delay == 0) busak_n = 1'b0;
    pulse_trig();
    waited = 0;
    while (busrq_v !== 1'b0 && waited < 50) begin @(negedge clk); waited++; end
    check_output({tag, "_req_low"}, 32'(busrq_v), 32'd0);
    check_output({tag, "_busy_hi"}, 32'(busy_v), 32'd1);
    if (ack_delay > 0) begin
      wait_steps(ack_delay);
      check_output({tag, "_wait_no_ce"}, 32'(ce_tot - ce0), 32'd0);
      check_output({tag, "_wait_no_rd"}, 32'(rd_q.size() - rd0), 32'd0);
      check_output({tag, "_wait_busrq"}, 32'(busrq_v), 32'd0);
      busak_n = 1'b0;
    end
    if (toggle) begin wait_steps(60); bank_in = ~bank; end
    if (retrig) begin wait_steps(90); pulse_trig(); end
    waited = 0;
    while (done_tot == done0 && waited < (3 * len + 100) * 3) begin @(negedge clk); waited++; end
    check_output({tag, "_done_seen"}, 32'(done_tot - done0), 32'd1);
    check_output({tag, "_rel_busrq"}, 32'(busrq_v), 32'd1);
    check_output({tag, "_rel_busy"}, 32'(busy_v), 32'd0);
    busak_n = 1'b1;
    wait_steps(30);
    check_output({tag, "_ce_cnt"}, 32'(ce_tot - ce0), 32'(len));
    check_output({tag, "_done_cnt"}, 32'(done_tot - done0), 32'd1);
    check_output({tag, "_rd_cnt"}, 32'(rd_q.size() - rd0), 32'(len));
    bad = 0;
    for (int n = 0; n < len && rd0 + n < rd_q.size(); n++) begin
      sa = base + 10'(n);
      if (rd_q[rd0 + n] !== sa) bad++;
    end
    check_output({tag, "_rd_addr_bad"}, 32'(bad), 32'd0);
    bad = 0;
    for (int n = 0; n < len; n++) begin
      sa = base + 10'(n);
      if (obj_seq[dst + n] <= ce0 || obj_m[dst + n] !== wram[sa]) bad++;
    end
    check_output({tag, "_obj_bad"}, 32'(bad), 32'd0);
    if (ack_delay == 0)
      check_output({tag, "_steps"}, 32'(step_tot - step0), 32'(2 + 3 * len + 1));
  endtask

  initial begin
    int ce0, done0, waited;
    bank_in = 1'b0;
    busak_n = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_busrq", 32'(bus0.O_BUSRQn), 32'd1);
    check_output("rst_rd", 32'(bus0.O_SRC_RDn), 32'd1);
    check_output("rst_ce", 32'(bus0.O_OBJ_DMA_CE), 32'd0);
    check_output("rst_busy", 32'(bus0.O_BUSY), 32'd0);
    check_output("rst_done", 32'(bus0.O_DONE), 32'd0);
    check_output("rst_src_a", 32'(bus0.O_SRC_A), 32'h100);
    check_output("rst_obj_a", 32'(bus0.O_OBJ_DMA_A), 32'd0);
    check_output("rst_obj_d", 32'(bus0.O_OBJ_DMA_D), 32'd0);
    check_output("rst_src_a1", 32'(bus1.O_SRC_A), 32'h3F0);

    $display("[TB] basic transfer, bank 0");
    apply_stimulus(1'b0, 2, 1'b0, 1'b0, 1'b0, "t1");
    $display("[TB] bank 1 with bank input toggled mid-transfer");
    apply_stimulus(1'b0, 2, 1'b1, 1'b1, 1'b0, "t2");
    $display("[TB] long acknowledge wait");
    apply_stimulus(1'b0, 1000, 1'b0, 1'b0, 1'b0, "t3");
    $display("[TB] retrigger during transfer");
    apply_stimulus(1'b0, 3, 1'b0, 1'b0, 1'b1, "t4");
    $display("[TB] wrapping source, short transfer");
    apply_stimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, "t5");

    $display("[TB] reset mid-transfer");
    sel = 1'b0;
    busak_n = 1'b0;
    ce0 = ce_tot;
    pulse_trig();
    waited = 0;
    while (ce_tot - ce0 < 11 && waited < 2000) begin @(negedge clk); waited++; end
    check_output("t6_reached_byte10", 32'(ce_tot - ce0), 32'd11);
    rst = 1'b1;
    @(negedge clk);
    check_output("t6_busrq", 32'(bus0.O_BUSRQn), 32'd1);
    check_output("t6_busy", 32'(bus0.O_BUSY), 32'd0);
    check_output("t6_ce", 32'(bus0.O_OBJ_DMA_CE), 32'd0);
    check_output("t6_obj_a", 32'(bus0.O_OBJ_DMA_A), 32'd0);
    check_output("t6_src_a", 32'(bus0.O_SRC_A), 32'h100);
    rst = 1'b0;
    busak_n = 1'b1;
    wait_steps(5);
    apply_stimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, "t6r");

    $display("[TB] trigger coincident with reset");
    done0 = done_tot;
    rst = 1'b1;
    trig = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    trig = 1'b0;
    wait_steps(20);
    check_output("t7_busy", 32'(bus0.O_BUSY), 32'd0);
    check_output("t7_busrq", 32'(bus0.O_BUSRQn), 32'd1);
    check_output("t7_done", 32'(done_tot - done0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mario_obj_dma.md
Name: mario_obj_dma

Overview:
Sprite DMA controller sitting directly upstream of the object (sprite) generator. On a CPU trigger it requests the Z80 bus, copies a block of sprite attribute bytes from CPU work RAM into the 1KB dual-port object RAM, then releases the bus. Its write port drives the object RAM DMA inputs (address, data, write enable). The line buffer / sprite scan logic only ever reads the result.

Parameters:
SRC_BASE, 10'h100, first work-RAM byte offset copied.
XFER_LEN, 384, bytes per transfer. Legal range 1..512; elaboration fails outside it.

Ports:
I_CLK_48M  in  1  sole clock
I_RESET  in  1  synchronous reset, active-high
I_CEN  in  1  DMA step enable (one I_CLK_48M cycle wide, CPU-rate)
I_TRIG  in  1  CPU write strobe to DMA start register; rising edge detected on I_CLK_48M
I_BANK  in  1  destination bank bit (object RAM A[9]); sampled at trigger
O_BUSRQn  out  1  Z80 bus request, active-low
I_BUSAKn  in  1  Z80 bus acknowledge, active-low
O_SRC_A  out  10  work RAM read address
O_SRC_RDn  out  1  work RAM read strobe, active-low
I_SRC_D  in  8  work RAM read data; synchronous, valid on the I_CEN step after address
O_OBJ_DMA_A  out  10  object RAM write address
O_OBJ_DMA_D  out  8  object RAM write data
O_OBJ_DMA_CE  out  1  object RAM write enable, exactly one I_CLK_48M cycle per byte
O_BUSY  out  1  high from accepted trigger until bus released
O_DONE  out  1  one-I_CLK_48M-cycle pulse when transfer completes

Behaviour:
- Reset values: O_BUSRQn=1, O_SRC_RDn=1, O_OBJ_DMA_CE=0, O_BUSY=0, O_DONE=0, O_SRC_A=SRC_BASE, O_OBJ_DMA_A=0, O_OBJ_DMA_D=0, byte index=0, state IDLE.
- State transitions other than IDLE->REQ occur only on cycles with I_CEN=1.
- Trigger edge detection runs every I_CLK_48M cycle. A rising edge while state IDLE is latched as pending.
- IDLE: on pending, capture I_BANK, clear index, set O_BUSY=1, go to REQ.
- REQ: drive O_BUSRQn=0, go to WAIT_ACK.
- WAIT_ACK: hold O_BUSRQn=0 indefinitely until I_BUSAKn=0 is sampled on a CEN step, then go to READ.
- READ: O_SRC_A = (SRC_BASE + index) mod 1024, O_SRC_RDn=0, go to LATCH.
- LATCH: capture I_SRC_D into the data register, O_SRC_RDn=1, go to WRITE.
- WRITE:
  - O_OBJ_DMA_A = {bank, index[8:0]}; O_OBJ_DMA_D = captured byte.
  - O_OBJ_DMA_CE=1 for the single I_CLK_48M cycle coincident with this CEN step; 0 on every other cycle.
  - Increment index. If the new index equals XFER_LEN go to RELEASE, else go to READ.
- RELEASE: O_BUSRQn=1, O_BUSY=0, O_DONE pulses for one cycle, go to IDLE.
- Throughput: 3 CEN steps per byte. A full transfer takes 2 + ack wait + 3*XFER_LEN + 1 CEN steps.
- O_OBJ_DMA_A/D hold their last values between writes. Object RAM port B reads are unaffected.
- Triggers while O_BUSY=1 are ignored, not queued.
- I_BUSAKn rising mid-transfer is ignored. The bus is assumed held until RELEASE.
- Source address wraps modulo 1024. Destination index never exceeds 9 bits because XFER_LEN is at most 512.
- Trigger and I_RESET in the same cycle: reset wins and the trigger is discarded.
- Reset mid-transfer: on the next clock the block returns to IDLE with all outputs at reset values. Partial object RAM contents are left as written.

Test Plan:
- SRC_BASE=10'h100, XFER_LEN=384, I_BANK=0, source byte k = k[7:0], ack 2 steps after request -> 384 CE pulses; object RAM addr n holds n[7:0] for n=0..383; O_DONE pulses once; O_BUSRQn high after last write.
- I_BANK=1 at trigger, toggled to 0 mid-transfer -> all writes go to addresses 0x200..0x37F.
- I_BUSAKn held high for 1000 steps -> O_BUSRQn stays low, no CE pulses and no source reads. Assert ack -> transfer completes normally.
- Second I_TRIG edge during a transfer -> ignored; exactly 384 CE pulses in total and one O_DONE.
- SRC_BASE=10'h3F0, XFER_LEN=32 -> source addresses 0x3F0..0x3FF then 0x000..0x00F.
- I_RESET asserted after byte 10 -> next clock O_BUSRQn=1, O_BUSY=0, CE=0; a new trigger restarts from index 0.
